gray_symbol_serializer: RTL and testbench

Parametrised successor to the 2-bit PAM4 Gray decoder on the Tx overflow path. It accepts Gray-coded PAM-N symbols of BITS_PER_SYM bits and converts each to binary. Decoded symbols are buffered in a small FIFO and serialised onto a 1-bit stream with valid/ready backpressure. It flags symbols dropped on overflow, and sits between the symbol source and the bit-level checker/BER counter.

---
 rtl/gray_pkg.sv | 26 ++
 rtl/gray_sym_fifo.sv | 63 ++++++
 rtl/gray_symbol_serializer.sv | 137 +++++++++++++
 tb/tb_gray_symbol_serializer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray symbol serializer and its FIFO.
package gray_pkg;

    localparam int unsigned PAM4_BITS    = 2;
    localparam int unsigned MAX_SYM_BITS = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Zero-extended input keeps the prefix XOR valid for any width up to MAX_SYM_BITS
    function automatic logic [MAX_SYM_BITS-1:0] gray2bin(input logic [MAX_SYM_BITS-1:0] g);
        logic [MAX_SYM_BITS-1:0] b;
        b[MAX_SYM_BITS-1] = g[MAX_SYM_BITS-1];
        for (int i = MAX_SYM_BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gray_sym_fifo.sv
// Synchronous symbol FIFO with registered write-ready, empty and level.
module gray_sym_fifo
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = PAM4_BITS,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LVL_W = lvl_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             wr_ready,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [LVL_W-1:0] level_d;

    assign do_push  = push && wr_ready;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        level_d = level;
        if (do_push && !do_pop) begin
            level_d = level + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level - LVL_W'(1);
        end
    end

    // wr_ready stays low through reset so nothing is accepted until the first edge after release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wr_ready <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level    <= level_d;
            wr_ready <= (level_d != LVL_W'(DEPTH));
            empty    <= (level_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gray_symbol_serializer.sv
// Gray-decodes PAM-N symbols, buffers them and serialises one bit per cycle with valid/ready.
// Optional GRAY_DEC_BYPASS_EN adds gray_bypass to write sym_in undecoded.
module gray_symbol_serializer
    import gray_pkg::*;
#(
    parameter int unsigned BITS_PER_SYM = PAM4_BITS,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MSB_FIRST    = 1,
    localparam int unsigned LVL_W = lvl_w(FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [BITS_PER_SYM-1:0] sym_in,
    input  logic                    sym_in_valid,
    output logic                    sym_in_ready,
    output logic                    bit_out,
    output logic                    bit_out_valid,
    input  logic                    bit_out_ready,
    output logic [LVL_W-1:0]        fifo_level,
    output logic                    drop_pulse,
    output logic                    overflow_sticky,
`ifdef GRAY_DEC_BYPASS_EN
    input  logic                    gray_bypass,
`endif
    input  logic                    clr_sticky
);

    localparam int unsigned CNT_W = $clog2(BITS_PER_SYM);

    logic [BITS_PER_SYM-1:0] dec_sym;
    logic [BITS_PER_SYM-1:0] fifo_data;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;

    ser_state_e              state_q, state_d;
    logic [BITS_PER_SYM-1:0] shreg_q, shreg_d, shift_next;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q;

`ifdef GRAY_DEC_BYPASS_EN
    assign dec_sym = gray_bypass ? sym_in
                                 : BITS_PER_SYM'(gray2bin(MAX_SYM_BITS'(sym_in)));
`else
    assign dec_sym = BITS_PER_SYM'(gray2bin(MAX_SYM_BITS'(sym_in)));
`endif

    gray_sym_fifo #(
        .WIDTH (BITS_PER_SYM),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (sym_in_valid),
        .push_data (dec_sym),
        .pop       (pop),
        .pop_data  (fifo_data),
        .wr_ready  (sym_in_ready),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Ready comes from a register, so a same-cycle pop on a full FIFO still drops the push
    assign drop = sym_in_valid && !sym_in_ready;

    assign shift_next = (MSB_FIRST != 0) ? {shreg_q[BITS_PER_SYM-2:0], 1'b0}
                                         : {1'b0, shreg_q[BITS_PER_SYM-1:1]};

    assign bit_out       = (MSB_FIRST != 0) ? shreg_q[BITS_PER_SYM-1] : shreg_q[0];
    assign bit_out_valid = valid_q;

    // Serialiser next state: load on pop, shift on accept, reload on the last bit without a bubble
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_data;
                    cnt_d   = CNT_W'(BITS_PER_SYM - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_out_ready) begin
                    if (cnt_q == '0) begin
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = fifo_data;
                            cnt_d   = CNT_W'(BITS_PER_SYM - 1);
                        end else begin
                            shreg_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d = shift_next;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == SHIFT);
        end
    end

    // A drop in the same cycle as clr_sticky leaves the flag set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_pulse      <= 1'b0;
            overflow_sticky <= 1'b0;
        end else begin
            drop_pulse <= drop;
            if (drop) begin
                overflow_sticky <= 1'b1;
            end else if (clr_sticky) begin
                overflow_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gray_symbol_serializer.sv
// Directed bench for gray_symbol_serializer: PAM4 MSB-first plus PAM8 in both bit orders.
module tb_gray_symbol_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [1:0] sym2;
    logic       v2, rdy2, clr2;
    logic       sir2, bo2, bov2, dp2, os2;
    logic [2:0] lvl2;

    logic [2:0] sym3;
    logic       v3, rdy3, clr3;
    logic       sir3a, bo3a, bov3a, dp3a, os3a;
    logic       sir3b, bo3b, bov3b, dp3b, os3b;
    logic [2:0] lvl3a, lvl3b;
`ifdef GRAY_DEC_BYPASS_EN
    logic       gbyp;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] got_vec;
    int          got_n, first_cyc, last_cyc, hold_err, drop_seen;
    logic [31:0] ga, gb;
    int          na, nb;

    gray_symbol_serializer #(.BITS_PER_SYM(2), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut2 (
        .clk(clk), .rstn(rstn), .sym_in(sym2), .sym_in_valid(v2), .sym_in_ready(sir2),
        .bit_out(bo2), .bit_out_valid(bov2), .bit_out_ready(rdy2), .fifo_level(lvl2),
        .drop_pulse(dp2), .overflow_sticky(os2),
`ifdef GRAY_DEC_BYPASS_EN
        .gray_bypass(gbyp),
`endif
        .clr_sticky(clr2));

    gray_symbol_serializer #(.BITS_PER_SYM(3), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut3m (
        .clk(clk), .rstn(rstn), .sym_in(sym3), .sym_in_valid(v3), .sym_in_ready(sir3a),
        .bit_out(bo3a), .bit_out_valid(bov3a), .bit_out_ready(rdy3), .fifo_level(lvl3a),
        .drop_pulse(dp3a), .overflow_sticky(os3a),
`ifdef GRAY_DEC_BYPASS_EN
        .gray_bypass(gbyp),
`endif
        .clr_sticky(clr3));

    gray_symbol_serializer #(.BITS_PER_SYM(3), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut3l (
        .clk(clk), .rstn(rstn), .sym_in(sym3), .sym_in_valid(v3), .sym_in_ready(sir3b),
        .bit_out(bo3b), .bit_out_valid(bov3b), .bit_out_ready(rdy3), .fifo_level(lvl3b),
        .drop_pulse(dp3b), .overflow_sticky(os3b),
`ifdef GRAY_DEC_BYPASS_EN
        .gray_bypass(gbyp),
`endif
        .clr_sticky(clr3));

    // Drives PAM4 symbols and a ready pattern per cycle; records accepted bits and hold violations
    task automatic run2(input logic [1:0] syms[$], input int nsym, input bit pat[$], input int ncyc);
        logic hold_pend, hold_bo;
        got_vec = '0; got_n = 0; first_cyc = -1; last_cyc = -1; hold_err = 0; drop_seen = 0;
        hold_pend = 1'b0; hold_bo = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (hold_pend && (bov2 !== 1'b1 || bo2 !== hold_bo)) hold_err++;
            if (dp2 === 1'b1) drop_seen++;
            v2   = (i < nsym);
            sym2 = (i < nsym) ? syms[i] : 2'b00;
            rdy2 = (i < pat.size()) ? pat[i] : 1'b1;
            hold_pend = bov2 && !rdy2;
            hold_bo   = bo2;
            if (bov2 && rdy2) begin
                got_vec = {got_vec[30:0], bo2};
                got_n++;
                if (first_cyc < 0) first_cyc = i;
                last_cyc = i;
            end
        end
    endtask

    task automatic run3(input logic [2:0] syms[$], input int nsym, input int ncyc);
        ga = '0; gb = '0; na = 0; nb = 0;
        rdy3 = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bov3a) begin ga = {ga[30:0], bo3a}; na++; end
            if (bov3b) begin gb = {gb[30:0], bo3b}; nb++; end
            v3   = (i < nsym);
            sym3 = (i < nsym) ? syms[i] : 3'b000;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; v2 = 0; sym2 = '0; rdy2 = 1'b1; clr2 = 0;
        v3 = 0; sym3 = '0; rdy3 = 1'b1; clr3 = 0;
`ifdef GRAY_DEC_BYPASS_EN
        gbyp = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_cmp++; if (sir2 !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", sir2); end
        n_cmp++; if (bov2 !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bov2); end
        n_cmp++; if (bo2 !== 1'b0) begin n_fail++; $display("FAIL rst_bit: got %b expected 0", bo2); end
        n_cmp++; if (lvl2 !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", lvl2); end
        n_cmp++; if (dp2 !== 1'b0 || os2 !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got %b%b expected 00", dp2, os2); end
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if (sir2 !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b expected 1", sir2); end
    endtask

    task automatic test_back_to_back();
        run2('{2'b00, 2'b01, 2'b11, 2'b10}, 4, '{1'b1}, 16);
        n_cmp++; if (got_n !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", got_n); end
        n_cmp++; if (got_vec[7:0] !== 8'b00011011) begin n_fail++; $display("FAIL b2b_bits: got %b expected 00011011", got_vec[7:0]); end
        n_cmp++; if (first_cyc !== 2) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 2", first_cyc); end
        n_cmp++; if (last_cyc - first_cyc !== 7) begin n_fail++; $display("FAIL b2b_bubble: got span %0d expected 7", last_cyc - first_cyc); end
        n_cmp++; if (drop_seen !== 0) begin n_fail++; $display("FAIL b2b_drop: got %0d expected 0", drop_seen); end
        n_cmp++; if (bov2 !== 1'b0 || lvl2 !== 3'd0) begin n_fail++; $display("FAIL b2b_idle: got valid %b level %0d expected 0 0", bov2, lvl2); end
    endtask

    task automatic test_pam8_order();
        run3('{3'b110, 3'b101}, 2, 14);
        n_cmp++; if (na !== 6) begin n_fail++; $display("FAIL pam8_msb_count: got %0d expected 6", na); end
        n_cmp++; if (ga[5:0] !== 6'b100110) begin n_fail++; $display("FAIL pam8_msb_bits: got %b expected 100110", ga[5:0]); end
        n_cmp++; if (nb !== 6) begin n_fail++; $display("FAIL pam8_lsb_count: got %0d expected 6", nb); end
        n_cmp++; if (gb[5:0] !== 6'b001011) begin n_fail++; $display("FAIL pam8_lsb_bits: got %b expected 001011", gb[5:0]); end
        n_cmp++; if (lvl3a !== 3'd0 || lvl3b !== 3'd0 || sir3a !== 1'b1 || sir3b !== 1'b1)
            begin n_fail++; $display("FAIL pam8_idle: got lvl %0d/%0d ready %b/%b expected 0/0 1/1", lvl3a, lvl3b, sir3a, sir3b); end
        n_cmp++; if ({dp3a, os3a, dp3b, os3b} !== 4'b0000) begin n_fail++; $display("FAIL pam8_flags: got %b expected 0000", {dp3a, os3a, dp3b, os3b}); end
    endtask

    task automatic test_overflow();
        logic [1:0] syms [6];
        syms = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
        rdy2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 4) begin
                n_cmp++; if (sir2 !== 1'b1 || lvl2 !== 3'd3) begin n_fail++; $display("FAIL ovf_pre: got ready %b level %0d expected 1 3", sir2, lvl2); end
            end
            if (i == 5) begin
                n_cmp++; if (sir2 !== 1'b0 || lvl2 !== 3'd4) begin n_fail++; $display("FAIL ovf_full: got ready %b level %0d expected 0 4", sir2, lvl2); end
                n_cmp++; if (dp2 !== 1'b0) begin n_fail++; $display("FAIL ovf_early_drop: got %b expected 0", dp2); end
            end
            if (i == 6) begin
                n_cmp++; if (dp2 !== 1'b1 || os2 !== 1'b1) begin n_fail++; $display("FAIL ovf_drop_set: got pulse %b sticky %b expected 1 1", dp2, os2); end
            end
            if (i == 7) begin
                n_cmp++; if (dp2 !== 1'b0 || os2 !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse_once: got pulse %b sticky %b expected 0 1", dp2, os2); end
                n_cmp++; if (lvl2 !== 3'd4 || bov2 !== 1'b1 || bo2 !== 1'b0) begin n_fail++; $display("FAIL ovf_hold: got level %0d valid %b bit %b expected 4 1 0", lvl2, bov2, bo2); end
            end
            v2   = (i < 6);
            sym2 = (i < 6) ? syms[i] : 2'b00;
            clr2 = (i == 5);
        end
        run2('{2'b00}, 0, '{1'b1}, 14);
        n_cmp++; if (got_n !== 10) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 10", got_n); end
        n_cmp++; if (got_vec[9:0] !== 10'b0110110001) begin n_fail++; $display("FAIL ovf_drain_bits: got %b expected 0110110001", got_vec[9:0]); end
        n_cmp++; if (last_cyc !== 9) begin n_fail++; $display("FAIL ovf_drain_bubble: got %0d expected 9", last_cyc); end
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        n_cmp++; if (os2 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", os2); end
    endtask

    task automatic test_backpressure();
        run2('{2'b11, 2'b01}, 2, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}, 14);
        n_cmp++; if (got_n !== 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", got_n); end
        n_cmp++; if (got_vec[3:0] !== 4'b1001) begin n_fail++; $display("FAIL bp_bits: got %b expected 1001", got_vec[3:0]); end
        n_cmp++; if (hold_err !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_err); end
        n_cmp++; if (drop_seen !== 0) begin n_fail++; $display("FAIL bp_drop: got %0d expected 0", drop_seen); end
    endtask

    task automatic test_reset_mid();
        run2('{2'b11, 2'b11, 2'b11}, 3, '{1'b1}, 3);
        @(posedge clk);
        #1;
        v2 = 1'b0;
        n_cmp++; if (bov2 !== 1'b1 || lvl2 !== 3'd2) begin n_fail++; $display("FAIL mid_pre: got valid %b level %0d expected 1 2", bov2, lvl2); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (bov2 !== 1'b0 || lvl2 !== 3'd0 || sir2 !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got valid %b level %0d ready %b expected 0 0 0", bov2, lvl2, sir2); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run2('{2'b01}, 1, '{1'b1}, 10);
        n_cmp++; if (got_n !== 2) begin n_fail++; $display("FAIL mid_after_count: got %0d expected 2", got_n); end
        n_cmp++; if (got_vec[1:0] !== 2'b01) begin n_fail++; $display("FAIL mid_after_bits: got %b expected 01", got_vec[1:0]); end
    endtask

    task automatic test_bypass();
`ifdef GRAY_DEC_BYPASS_EN
        gbyp = 1'b1;
        run2('{2'b11}, 1, '{1'b1}, 8);
        n_cmp++; if (got_n !== 2 || got_vec[1:0] !== 2'b11) begin n_fail++; $display("FAIL bypass_on: got %0d bits %b expected 2 bits 11", got_n, got_vec[1:0]); end
        gbyp = 1'b0;
`endif
        run2('{2'b11}, 1, '{1'b1}, 8);
        n_cmp++; if (got_n !== 2 || got_vec[1:0] !== 2'b10) begin n_fail++; $display("FAIL bypass_off: got %0d bits %b expected 2 bits 10", got_n, got_vec[1:0]); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_pam8_order();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
